// File: rtl/max7219_pkg.sv
// ----------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219 link sniffer: register addresses of the
// MAX7219 command word, the word layout and per-device geometry.
// ----------------------------------------------------------------------------
package max7219_pkg;

    localparam int WORD_W       = 16;  // bits per device in the daisy chain
    localparam int ROWS_PER_DEV = 8;   // digit rows per device

    // MAX7219 register addresses (word[11:8])
    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    // One 16-bit command word as it arrives MSB first.
    typedef struct packed {
        logic [3:0] rsvd;  // don't-care bits
        logic [3:0] addr;
        logic [7:0] data;
    } max7219_word_t;

endpackage

// File: rtl/max7219_input_sync.sv
// ----------------------------------------------------------------------------
// max7219_input_sync
// Brings one asynchronous line into the clk domain: 2-FF synchronizer followed
// by one history register for edge detection.
//   clk, rst_n : system clock, async active-low reset
//   async_in   : raw asynchronous input
//   level      : synchronized level
//   rise, fall : single-cycle edge strobes, aligned with level
// RST_VAL sets the idle level so that leaving reset never fakes an edge.
// ----------------------------------------------------------------------------
module max7219_input_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/max7219_sniffer.sv
// ----------------------------------------------------------------------------
// max7219_sniffer
// Receive-side model of a MAX7219 daisy chain. Oversamples CS/SCLK/DIN,
// deserialises NUM_DEVICES 16-bit words and applies each LOAD to per-device
// shadows (8 digit rows, intensity, shutdown, display-test).
//   clk, rst_n            : system clock, async active-low reset
//   max_cs/sclk/din       : asynchronous serial link
//   rd_addr / rd_data     : row read port (device*8 + digit-1), 1-cycle latency
//   frame_update          : pulse, valid LOAD applied
//   frame_error           : pulse, LOAD rejected (bit count != 16*NUM_DEVICES)
//   shutdown/disp_test    : one bit per device
//   intensity             : one nibble per device
// ----------------------------------------------------------------------------
module max7219_sniffer
    import max7219_pkg::*;
#(
    parameter int NUM_DEVICES = 16,
    parameter int ROW_AW      = $clog2(NUM_DEVICES * 8)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     max_cs,
    input  logic                     max_sclk,
    input  logic                     max_din,
    input  logic [ROW_AW-1:0]        rd_addr,
    output logic [7:0]               rd_data,
    output logic                     frame_update,
    output logic                     frame_error,
    output logic [NUM_DEVICES-1:0]   shutdown,
    output logic [NUM_DEVICES-1:0]   disp_test,
    output logic [4*NUM_DEVICES-1:0] intensity
);

    localparam int FRAME_BITS = WORD_W * NUM_DEVICES;
    localparam int NUM_ROWS   = ROWS_PER_DEV * NUM_DEVICES;
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic din_level, din_rise_unused, din_fall_unused;

    // CS idles high, so its synchronizer resets high.
    max7219_input_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .async_in(max_cs),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    max7219_input_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .async_in(max_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );
    max7219_input_sync #(.RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .async_in(max_din),
        .level(din_level), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    logic [FRAME_BITS-1:0] sr, sr_next;
    logic [CNT_W-1:0]      bit_cnt, cnt_next;
    logic [7:0]            rows [NUM_ROWS];
    max7219_word_t         words [NUM_DEVICES];
    logic                  rsvd_unused;

    // CS as it was before this sample: an SCLK edge landing together with the
    // CS rise still belongs to the frame; one landing with the CS fall does not.
    logic cs_low_pre;
    logic shift_en;
    assign cs_low_pre = cs_rise | (~cs_level & ~cs_fall);
    assign shift_en   = sclk_rise & cs_low_pre;

    // Shift result is computed ahead so a simultaneous CS rise checks the
    // count that includes the final bit.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sr_next     = sr;
        cnt_next    = bit_cnt;
        rsvd_unused = 1'b0;
        if (shift_en) begin
            sr_next = {sr[FRAME_BITS-2:0], din_level};
            if (bit_cnt != CNT_SAT) cnt_next = bit_cnt + CNT_W'(1);
        end
        // Device 0 is nearest DIN, so its word is the last one shifted in.
        for (int k = 0; k < NUM_DEVICES; k++) begin
            words[k]    = max7219_word_t'(sr_next[WORD_W*k +: WORD_W]);
            rsvd_unused = rsvd_unused ^ (^words[k].rsvd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr           <= '0;
            bit_cnt      <= '0;
            rd_data      <= 8'h00;
            frame_update <= 1'b0;
            frame_error  <= 1'b0;
            shutdown     <= '1;
            disp_test    <= '0;
            intensity    <= '0;
            // NOTE: the row array is reset because the readout must show a
            // blank grid before the first LOAD; a RAM could not do this.
            for (int r = 0; r < NUM_ROWS; r++) rows[r] <= 8'h00;
        end else begin
            frame_update <= 1'b0;
            frame_error  <= 1'b0;
            sr           <= sr_next;
            bit_cnt      <= cs_fall ? '0 : cnt_next;
            rd_data      <= rows[rd_addr];

            if (cs_rise) begin
                if (cnt_next == CNT_FULL) begin
                    frame_update <= 1'b1;
                    for (int k = 0; k < NUM_DEVICES; k++) begin
                        case (words[k].addr)
                            REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                            REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                                rows[ROW_AW'(k * ROWS_PER_DEV + int'(words[k].addr) - 1)]
                                    <= words[k].data;
                            REG_INTENSITY: intensity[4*k +: 4] <= words[k].data[3:0];
                            REG_SHUTDOWN:  shutdown[k]  <= ~words[k].data[0];
                            REG_TEST:      disp_test[k] <= words[k].data[0];
                            // NOOP, DECODE, SCANLIMIT and 0xD/0xE have no
                            // visible effect on the captured image.
                            default: ;
                        endcase
                    end
                end else begin
                    frame_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_sniffer.sv
// ----------------------------------------------------------------------------
// tb_max7219_sniffer
// Directed bench for a 2-device chain. Each LOAD pushes the expected outcome
// (update or error, plus the full shadow state) onto a scoreboard; when the
// DUT pulses, the entry is popped and compared, including every row.
// ----------------------------------------------------------------------------
module tb_max7219_sniffer;
    import max7219_pkg::*;

    localparam int N  = 2;
    localparam int AW = $clog2(N * 8);
    localparam int NR = N * 8;

    logic           clk;
    logic           rst_n;
    logic           max_cs, max_sclk, max_din;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_data;
    logic           frame_update, frame_error;
    logic [N-1:0]   shutdown, disp_test;
    logic [4*N-1:0] intensity;

    max7219_sniffer #(.NUM_DEVICES(N), .ROW_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .max_cs(max_cs), .max_sclk(max_sclk), .max_din(max_din),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_update(frame_update), .frame_error(frame_error),
        .shutdown(shutdown), .disp_test(disp_test), .intensity(intensity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (frame_update === 1'b1) upd_cnt++;
        if (frame_error === 1'b1) err_cnt++;
    end

    typedef struct packed {
        logic             upd;
        logic [N-1:0]     sd;
        logic [N-1:0]     dt;
        logic [4*N-1:0]   inten;
        logic [NR*8-1:0]  rows;
    } exp_t;

    exp_t sb[$];

    logic [7:0]     m_rows [NR];
    logic [N-1:0]   m_sd, m_dt;
    logic [4*N-1:0] m_int;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) m_rows[r] = 8'h00;
        m_sd  = '1;
        m_dt  = '0;
        m_int = '0;
    endtask

    task automatic model_apply(input logic [16*N-1:0] f);
        logic [15:0] w;
        logic [3:0]  a;
        logic [7:0]  d;
        for (int k = 0; k < N; k++) begin
            w = f[16*k +: 16];
            a = w[11:8];
            d = w[7:0];
            if (a >= 4'h1 && a <= 4'h8) m_rows[k*8 + int'(a) - 1] = d;
            else case (a)
                REG_INTENSITY: m_int[4*k +: 4] = d[3:0];
                REG_SHUTDOWN:  m_sd[k] = ~d[0];
                REG_TEST:      m_dt[k] = d[0];
                default: ;
            endcase
        end
    endtask

    function automatic exp_t snapshot(input logic upd);
        exp_t e;
        e.upd   = upd;
        e.sd    = m_sd;
        e.dt    = m_dt;
        e.inten = m_int;
        for (int r = 0; r < NR; r++) e.rows[8*r +: 8] = m_rows[r];
        return e;
    endfunction

    task automatic read_row(input int r, output logic [7:0] d);
        @(negedge clk) rd_addr = AW'(r);
        @(negedge clk) d = rd_data;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        logic [7:0] d;
        check($sformatf("%s_shutdown", tag), 32'(shutdown), 32'(e.sd));
        check($sformatf("%s_disp_test", tag), 32'(disp_test), 32'(e.dt));
        check($sformatf("%s_intensity", tag), 32'(intensity), 32'(e.inten));
        for (int r = 0; r < NR; r++) begin
            read_row(r, d);
            check($sformatf("%s_row%0d", tag, r), 32'(d), 32'(e.rows[8*r +: 8]));
        end
    endtask

    task automatic shift_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk) max_din = bits[i];
            repeat (2) @(negedge clk);
            max_sclk = 1'b1;
            repeat (3) @(negedge clk);
            max_sclk = 1'b0;
        end
    endtask

    // Drive one LOAD of n bits, push the expectation, then pop and compare.
    task automatic send(input string tag, input logic [63:0] bits, input int n);
        int   u0, e0, waited;
        exp_t e;
        u0 = upd_cnt;
        e0 = err_cnt;
        @(negedge clk) max_cs = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(bits, n);
        repeat (3) @(negedge clk);
        if (n == 16 * N) model_apply(bits[16*N-1:0]);
        sb.push_back(snapshot(n == 16 * N));
        max_cs = 1'b1;
        waited = 0;
        while (upd_cnt == u0 && err_cnt == e0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s_pulse_seen", tag), 32'(waited < 30), 32'd1);
        repeat (4) @(negedge clk);
        e = sb.pop_front();
        check($sformatf("%s_update_cnt", tag), 32'(upd_cnt - u0), 32'(e.upd));
        check($sformatf("%s_error_cnt", tag), 32'(err_cnt - e0), 32'(!e.upd));
        check_state(tag, e);
    endtask

    initial begin
        logic [7:0] d;
        int u0, e0;
        rst_n    = 1'b0;
        max_cs   = 1'b1;
        max_sclk = 1'b0;
        max_din  = 1'b0;
        rd_addr  = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_frame_update", 32'(frame_update), 32'd0);
        check("rst_frame_error", 32'(frame_error), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_pulse", 32'(upd_cnt + err_cnt), 32'd0);
        check_state("rst", snapshot(1'b0));

        // Single digit write to device 0, digit 3
        send("digit", 64'({16'h0000, 16'h0355}), 32);
        read_row(2, d);
        check("digit_row2_const", 32'(d), 32'h55);
        read_row(10, d);
        check("digit_row10_const", 32'(d), 32'h00);

        // Config registers
        send("cfg", 64'({16'h0C01, 16'h0A0F}), 32);
        check("cfg_shutdown_const", 32'(shutdown), 32'b01);
        check("cfg_intensity0_const", 32'(intensity[3:0]), 32'hF);
        send("test", 64'({16'h0F01, 16'h0F01}), 32);
        check("test_disp_const", 32'(disp_test), 32'b11);

        // Short, long and empty LOADs are rejected
        send("short", 64'h0000_0000_5155_0155, 31);
        send("long",  64'h0000_0001_0466_0377, 33);
        send("empty", 64'h0, 0);

        // Stray SCLK edges with CS high are ignored
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) max_din = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk);
            max_sclk = 1'b1;
            repeat (3) @(negedge clk);
            max_sclk = 1'b0;
        end
        send("gated", 64'({16'h0811, 16'h01AA}), 32);

        // Reset mid-frame, then a clean frame
        @(negedge clk) max_cs = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(64'h3FF, 10);
        u0 = upd_cnt;
        e0 = err_cnt;
        @(negedge clk);
        rst_n    = 1'b0;
        max_cs   = 1'b1;
        max_sclk = 1'b0;
        #1;
        check("mid_rst_shutdown", 32'(shutdown), 32'b11);
        check("mid_rst_intensity", 32'(intensity), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_rst_no_pulse", 32'((upd_cnt - u0) + (err_cnt - e0)), 32'd0);
        model_reset();
        check_state("mid_rst", snapshot(1'b0));
        send("post_rst", 64'({16'h0A05, 16'h0C01}), 32);
        check("post_rst_shutdown_const", 32'(shutdown), 32'b10);
        check("post_rst_intensity_const", 32'(intensity), 32'h50);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
